// File: rtl/host_loader.sv
`default_nettype none
// ============================================================================
// host_loader -- parses CMD/ADDR/LEN/data packets from a host stream and
//                writes the data words into the TPU input or weight buffer.
// Revision: 1.0
// ============================================================================
module host_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  abort,
  output logic                  mem_wr_en,
  output logic                  mem_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  load_done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_LEN  = 3'd2,
    DATA     = 3'd3,
    ERR      = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_count;
  logic                  w_beat;
  logic                  w_cmd_ok;

  // Status flags decode directly from the state register, so they are glitch-free
  // and take their reset values as soon as reset asserts.
  assign s_ready  = (r_state != ERR);
  assign busy     = (r_state != IDLE) && (r_state != ERR);
  assign error    = (r_state == ERR);
  assign w_beat   = s_valid && s_ready;
  // CMD layout: opcode nibble 4'hA in [7:4], [3:1] reserved zero, [0] buffer select.
  assign w_cmd_ok = (s_data[7:4] == 4'hA) && (s_data[3:1] == 3'b000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_count   <= '0;
      mem_wr_en <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      load_done <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      load_done <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_count <= '0;
      end else if (w_beat) begin
        case (r_state)
          IDLE: begin
            if (w_cmd_ok) begin
              mem_sel <= s_data[0];
              r_state <= GET_ADDR;
            end else begin
              r_state <= ERR;
            end
          end
          GET_ADDR: begin
            r_addr  <= s_data[ADDR_WIDTH-1:0];
            r_state <= GET_LEN;
          end
          GET_LEN: begin
            if (s_data == '0) begin
              r_state <= ERR;
            end else begin
              r_count <= s_data;
              r_state <= DATA;
            end
          end
          DATA: begin
            mem_wr_en <= 1'b1;
            mem_addr  <= r_addr;
            mem_data  <= s_data;
            r_addr    <= r_addr + 1'b1;
            r_count   <= r_count - 1'b1;
            if (r_count == DATA_WIDTH'(1)) begin
              load_done <= 1'b1;
              r_state   <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_host_loader.sv
`default_nettype none
// ============================================================================
// tb_host_loader -- directed packet vectors for host_loader.
// Revision: 1.0
// ============================================================================
module tb_host_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       abort = 1'b0;
  logic       mem_wr_en;
  logic       mem_sel;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       busy;
  logic       load_done;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int wr_base;
  int done_base;

  host_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .abort(abort), .mem_wr_en(mem_wr_en),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .load_done(load_done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr_en) wr_cnt++;
    if (load_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word with s_valid high and advance past the next rising edge.
  task automatic send(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [7:0] d, input logic [7:0] a,
                           input logic sel, input logic done);
    send(d);
    check("wr_en", mem_wr_en, 1'b1);
    check("addr", mem_addr, a);
    check("data", mem_data, d);
    check("sel", mem_sel, sel);
    check("load_done", load_done, done);
  endtask

  initial begin
    #2;
    check("rst s_ready", s_ready, 1'b1);
    check("rst wr_en", mem_wr_en, 1'b0);
    check("rst sel", mem_sel, 1'b0);
    check("rst addr", mem_addr, 8'h00);
    check("rst data", mem_data, 8'h00);
    check("rst busy", busy, 1'b0);
    check("rst done", load_done, 1'b0);
    check("rst error", error, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic packet into the weight buffer, s_valid held high.
    send(8'hA1);
    check("busy after cmd", busy, 1'b1);
    send(8'h10);
    send(8'h03);
    check("no wr in header", mem_wr_en, 1'b0);
    send_data(8'h11, 8'h10, 1'b1, 1'b0);
    send_data(8'h22, 8'h11, 1'b1, 1'b0);
    send_data(8'h33, 8'h12, 1'b1, 1'b1);
    check("busy after pkt", busy, 1'b0);
    gap();
    check("wr_en drops", mem_wr_en, 1'b0);
    check("done drops", load_done, 1'b0);
    check("addr holds", mem_addr, 8'h12);

    // Address wrap-around.
    done_base = done_cnt;
    send(8'hA0); send(8'hFE); send(8'h03);
    send_data(8'h01, 8'hFE, 1'b0, 1'b0);
    send_data(8'h02, 8'hFF, 1'b0, 1'b0);
    send_data(8'h03, 8'h00, 1'b0, 1'b1);
    gap();
    check("wrap done count", done_cnt - done_base, 1);
    check("wrap error", error, 1'b0);

    // Bad CMD, blocked stream, abort recovery.
    wr_base = wr_cnt;
    send(8'h5F);
    check("bad cmd error", error, 1'b1);
    check("bad cmd ready", s_ready, 1'b0);
    check("bad cmd busy", busy, 1'b0);
    send(8'hA0);
    check("err sticky", error, 1'b1);
    s_valid = 1'b0;
    abort   = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort error", error, 1'b0);
    check("abort ready", s_ready, 1'b1);
    check("err no writes", wr_cnt - wr_base, 0);
    send(8'hA0); send(8'h00); send(8'h01);
    send_data(8'h77, 8'h00, 1'b0, 1'b1);
    gap();

    // Zero-length packet.
    wr_base = wr_cnt;
    send(8'hA0); send(8'h20);
    check("len pending err", error, 1'b0);
    send(8'h00);
    check("len0 error", error, 1'b1);
    send(8'h44);
    gap();
    check("len0 no writes", wr_cnt - wr_base, 0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;

    // Abort coinciding with a data beat suppresses the write.
    wr_base = wr_cnt;
    send(8'hA0); send(8'h50); send(8'h02);
    abort = 1'b1;
    send(8'hEE);
    abort = 1'b0;
    check("abort wr_en", mem_wr_en, 1'b0);
    check("abort busy", busy, 1'b0);
    gap();
    check("abort no writes", wr_cnt - wr_base, 0);

    // Toggling valid, then a back-to-back packet.
    wr_base   = wr_cnt;
    done_base = done_cnt;
    send(8'hA1); gap();
    send(8'h40); gap();
    send(8'h04); gap();
    send_data(8'hAA, 8'h40, 1'b1, 1'b0); gap();
    check("stall holds busy", busy, 1'b1);
    send_data(8'hBB, 8'h41, 1'b1, 1'b0); gap();
    send_data(8'hCC, 8'h42, 1'b1, 1'b0); gap();
    send_data(8'hDD, 8'h43, 1'b1, 1'b1);
    send(8'hA0);
    check("b2b cmd taken", busy, 1'b1);
    send(8'h00); send(8'h01);
    send_data(8'h55, 8'h00, 1'b0, 1'b1);
    gap();
    check("toggle writes", wr_cnt - wr_base, 5);
    check("toggle dones", done_cnt - done_base, 2);

    // Reset mid-packet.
    send(8'hA1); send(8'h30); send(8'h04);
    send_data(8'h01, 8'h30, 1'b1, 1'b0);
    send_data(8'h02, 8'h31, 1'b1, 1'b0);
    s_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("mid rst wr_en", mem_wr_en, 1'b0);
    check("mid rst addr", mem_addr, 8'h00);
    check("mid rst data", mem_data, 8'h00);
    check("mid rst sel", mem_sel, 1'b0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst ready", s_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(8'hA0); send(8'h08); send(8'h01);
    send_data(8'h99, 8'h08, 1'b0, 1'b1);
    gap();
    check("final busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/host_loader.md
HOST_LOADER -- requirements
Module: host_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of stream words and memory data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, width of memory address; ADDR_WIDTH <= DATA_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_data  input  DATA_WIDTH  host stream word.
REQ-006 SHALL have port s_valid  input  1  host word valid.
REQ-007 SHALL have port s_ready  output  1  loader accepts word.
REQ-008 SHALL have port abort  input  1  synchronous return to IDLE, clears error.
REQ-009 SHALL have port mem_wr_en  output  1  one-cycle write strobe to TPU buffer.
REQ-010 SHALL have port mem_sel  output  1  target buffer: 0 = input buffer, 1 = weight buffer.
REQ-011 SHALL have port mem_addr  output  ADDR_WIDTH  write address.
REQ-012 SHALL have port mem_data  output  DATA_WIDTH  write data.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE and ERR.
REQ-014 SHALL have port load_done  output  1  one-cycle pulse on final write of a packet.
REQ-015 SHALL have port error  output  1  sticky malformed-packet flag.

Function
REQ-016 SHALL transfer a word only on a rising edge with s_valid=1 and s_ready=1 (a beat).
REQ-017 SHALL accept packets: CMD word, ADDR word, LEN word, then LEN data words.
REQ-018 SHALL validate CMD: bits[7:4] = 4'hA and bits[3:1] = 0; bit0 gives mem_sel.
REQ-019 SHALL implement states IDLE, GET_ADDR, GET_LEN, DATA, ERR.
REQ-020 IDLE: s_ready=1; valid CMD beat -> GET_ADDR, latch mem_sel; invalid CMD beat -> ERR.
REQ-021 GET_ADDR: s_ready=1; beat latches addr = s_data[ADDR_WIDTH-1:0] -> GET_LEN.
REQ-022 GET_LEN: s_ready=1; beat with LEN=0 -> ERR; else latch remaining count = LEN -> DATA.
REQ-023 DATA: s_ready=1; each beat decrements count; beat with count=1 -> IDLE.
REQ-024 ERR: s_ready=0, error=1, no writes; exit only via abort or reset.
REQ-025 SHALL register each data beat to the memory port: mem_wr_en=1 exactly one cycle after the beat, mem_addr/mem_data valid in that same cycle.
REQ-026 SHALL write beat k (0-based) at address (ADDR + k) mod 2^ADDR_WIDTH; wrap-around is legal and not an error.
REQ-027 SHALL assert load_done in the same cycle as mem_wr_en for the final data word.
REQ-028 SHALL accept the next packet's CMD beat in the cycle after the final data beat (back-to-back packets, no bubble).
REQ-029 SHALL hold state and counters unchanged while s_valid=0 (host stalls anywhere, including mid-header).
REQ-030 abort=1 SHALL force IDLE, clear error, and suppress any pending write at the next edge; abort has priority over a simultaneous beat.
REQ-031 mem_wr_en SHALL be 0 in every cycle not following a data beat; mem_addr/mem_data hold last values otherwise.

Reset
REQ-032 reset=0 SHALL immediately force IDLE and s_ready=1, mem_wr_en=0, mem_sel=0, mem_addr=0, mem_data=0, busy=0, load_done=0, error=0, count=0.
REQ-033 Reset asserted mid-packet SHALL discard the packet; the first packet after release starts from CMD.

Verification
REQ-034 Stream A1,10,03,11,22,33 with s_valid held high -> writes sel=1 at 0x10/0x11/0x12 = 11/22/33 one cycle after each beat, load_done with 0x12 write, busy=0 afterwards.
REQ-035 Stream A0,FE,03,01,02,03 -> sel=0 writes at FE,FF,00 (wrap), load_done once, error=0.
REQ-036 Stream 5F then A0 -> error=1, s_ready=0, no writes; abort pulse -> error=0, s_ready=1, then A0,00,01,77 writes 0x77 at 0x00.
REQ-037 Stream A0,20,00 -> ERR after LEN beat, no mem_wr_en ever asserted.
REQ-038 Packet A1,40,04 + 4 data with s_valid toggling every cycle, then a back-to-back packet A0,00,01,55 -> 5 writes in order, correct addresses, two load_done pulses.
REQ-039 Assert reset after 2 of 4 data beats -> outputs at reset values immediately; next packet A0,08,01,99 writes 0x99 at 0x08.
